// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared widths, ALU mode/aluop codes, funct/opcode constants
package alu_operand_stage_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic HIGH = 1'b1;
  localparam logic LOW = 1'b0;
  typedef enum logic [1:0] {
    AOP_ADDR   = 2'b00,
    AOP_BRANCH = 2'b01,
    AOP_RTYPE  = 2'b10,
    AOP_ITYPE  = 2'b11
  } aluop_e;
  typedef enum logic [2:0] {
    M_AND  = 3'b000,
    M_OR   = 3'b001,
    M_SLL  = 3'b010,
    M_SLT  = 3'b011,
    M_ADD  = 3'b100,
    M_ADDU = 3'b101,
    M_SUB  = 3'b110,
    M_SRL  = 3'b111
  } alu_mode_e;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_ADDU = 6'h21,
                         F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
  typedef struct packed {
    alu_mode_e m;
    logic      illegal;
    logic      a_shamt;
    logic      a_lui;
    logic      b_zext;
  } ctrl_t;
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: request side and ALU-operand side handshake bundle
interface alu_operand_stage_if #(parameter int WIDTH = alu_operand_stage_pkg::DATA_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       aluop;
  logic [1:0]       a_sel;
  logic [1:0]       b_sel;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [15:0]      imm;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_m;
  logic             illegal;
  modport master (
    output in_valid, aluop, a_sel, b_sel, opcode, funct, shamt, imm, pc, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_m, illegal
  );
  modport slave (
    input  in_valid, aluop, a_sel, b_sel, opcode, funct, shamt, imm, pc, rs_data, rt_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_m, illegal
  );
endinterface

// File: rtl/alu_operand_stage_ctrl_decode.sv
// alu_ctrl_decode: aluop/opcode/funct -> ALU mode, illegal flag and operand overrides
module alu_ctrl_decode
  import alu_operand_stage_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '{m: M_ADDU, illegal: LOW, a_shamt: LOW, a_lui: LOW, b_zext: LOW};
    case (aluop)
      AOP_ADDR:   ctrl.m = M_ADDU;
      AOP_BRANCH: ctrl.m = M_SUB;
      AOP_RTYPE:
        case (funct)
          F_ADD:   ctrl.m = M_ADD;
          F_ADDU:  ctrl.m = M_ADDU;
          F_SUB:   ctrl.m = M_SUB;
          F_AND:   ctrl.m = M_AND;
          F_OR:    ctrl.m = M_OR;
          F_SLT:   ctrl.m = M_SLT;
          F_SLL:   begin ctrl.m = M_SLL; ctrl.a_shamt = HIGH; end
          F_SRL:   begin ctrl.m = M_SRL; ctrl.a_shamt = HIGH; end
          default: ctrl.illegal = HIGH;
        endcase
      default:
        case (opcode)
          OP_ADDI:  ctrl.m = M_ADD;
          OP_ADDIU: ctrl.m = M_ADDU;
          OP_SLTI:  ctrl.m = M_SLT;
          OP_ANDI:  begin ctrl.m = M_AND; ctrl.b_zext = HIGH; end
          OP_ORI:   begin ctrl.m = M_OR; ctrl.b_zext = HIGH; end
          // lui is realised as zext(imm) << 16 in the ALU shifter
          OP_LUI:   begin ctrl.m = M_SLL; ctrl.a_lui = HIGH; ctrl.b_zext = HIGH; end
          default:  ctrl.illegal = HIGH;
        endcase
    endcase
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand selection and decode into an in-order buffer feeding the ALU
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  alu_operand_stage_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  ctrl_t            ctrl;
  logic [WIDTH-1:0] imm_s, imm_z, shamt_z, sel_a, sel_b;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [2:0]       mem_m [DEPTH];
  logic             mem_ill [DEPTH];
  logic [PW-1:0]    wr, rd;
  logic [CW-1:0]    count, count_nx;
  logic             ready_q, push, pop;
  alu_ctrl_decode u_dec (
    .aluop  (bus.aluop),
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .ctrl   (ctrl)
  );
  assign imm_s   = {{(WIDTH-16){bus.imm[15]}}, bus.imm};
  assign imm_z   = {{(WIDTH-16){1'b0}}, bus.imm};
  assign shamt_z = {{(WIDTH-5){1'b0}}, bus.shamt};
  assign sel_a = ctrl.a_lui          ? WIDTH'(16) :
                 ctrl.a_shamt        ? shamt_z :
                 bus.a_sel == 2'b00  ? bus.pc :
                 bus.a_sel == 2'b01  ? bus.rs_data :
                 bus.a_sel == 2'b10  ? shamt_z : '0;
  assign sel_b = ctrl.b_zext         ? imm_z :
                 bus.b_sel == 2'b00  ? bus.rt_data :
                 bus.b_sel == 2'b01  ? WIDTH'(4) :
                 bus.b_sel == 2'b10  ? imm_s : imm_s << 2;
  assign push     = bus.in_valid & ready_q;
  assign pop      = bus.out_valid & bus.out_ready;
  assign count_nx = count + CW'(push) - CW'(pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      wr      <= '0;
      rd      <= '0;
      ready_q <= HIGH;
    end else if (flush) begin
      count   <= '0;
      wr      <= '0;
      rd      <= '0;
      ready_q <= HIGH;
    end else begin
      count   <= count_nx;
      ready_q <= count_nx != CW'(DEPTH);
      if (push) wr <= wr + PW'(1);
      if (pop) rd <= rd + PW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_a[wr]   <= sel_a;
      mem_b[wr]   <= sel_b;
      mem_m[wr]   <= ctrl.m;
      mem_ill[wr] <= ctrl.illegal;
    end
  end
  // empty buffer presents reset values so the ALU never sees stale entries
  assign bus.in_ready  = ready_q;
  assign bus.out_valid = count != '0;
  assign bus.alu_a     = bus.out_valid ? mem_a[rd] : '0;
  assign bus.alu_b     = bus.out_valid ? mem_b[rd] : '0;
  assign bus.alu_m     = bus.out_valid ? mem_m[rd] : M_ADDU;
  assign bus.illegal   = bus.out_valid ? mem_ill[rd] : LOW;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed checks of decode, operand muxes, buffering, flush and reset
module tb_alu_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;
  alu_operand_stage_if #(.WIDTH(32)) bus ();
  alu_operand_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic head(input string tag, input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] m, input logic il);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".a"}, bus.alu_a, a);
    chk({tag, ".b"}, bus.alu_b, b);
    chk({tag, ".m"}, 32'(bus.alu_m), 32'(m));
    chk({tag, ".ill"}, 32'(bus.illegal), 32'(il));
  endtask
  task automatic req(input logic [1:0] op, input logic [1:0] as, input logic [1:0] bs,
                     input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                     input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.aluop = op;
    bus.a_sel = as;
    bus.b_sel = bs;
    bus.opcode = opc;
    bus.funct = fn;
    bus.shamt = sh;
    bus.imm = im;
    bus.rs_data = rs;
    bus.rt_data = rt;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.aluop = 2'b00;
    bus.a_sel = 2'b00;
    bus.b_sel = 2'b00;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.shamt = 5'd0;
    bus.imm = 16'h0000;
    bus.pc = 32'h0000_0100;
    bus.rs_data = '0;
    bus.rt_data = '0;
    #12;
    head("reset", 1'b0, 32'd0, 32'd0, 3'b101, 1'b0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    // decode and operand selection, one entry per cycle with out_ready=1
    req(2'b10, 2'b01, 2'b00, 6'h00, 6'h20, 5'd0, 16'h0000, 32'd5, 32'd7); tick();
    head("r_add", 1'b1, 32'd5, 32'd7, 3'b100, 1'b0);
    req(2'b10, 2'b01, 2'b00, 6'h00, 6'h00, 5'd3, 16'h0000, 32'd9, 32'd1); tick();
    head("sll", 1'b1, 32'd3, 32'd1, 3'b010, 1'b0);
    req(2'b10, 2'b00, 2'b00, 6'h00, 6'h02, 5'd31, 16'h0000, 32'd9, 32'h8000_0000); tick();
    head("srl", 1'b1, 32'd31, 32'h8000_0000, 3'b111, 1'b0);
    req(2'b11, 2'b00, 2'b00, 6'h0F, 6'h00, 5'd0, 16'h1234, 32'd9, 32'd9); tick();
    head("lui", 1'b1, 32'd16, 32'h0000_1234, 3'b010, 1'b0);
    req(2'b11, 2'b01, 2'b10, 6'h08, 6'h00, 5'd0, 16'hFFFC, 32'd5, 32'd0); tick();
    head("addi", 1'b1, 32'd5, 32'hFFFF_FFFC, 3'b100, 1'b0);
    req(2'b11, 2'b01, 2'b10, 6'h0D, 6'h00, 5'd0, 16'hFFFC, 32'd5, 32'd0); tick();
    head("ori", 1'b1, 32'd5, 32'h0000_FFFC, 3'b001, 1'b0);
    req(2'b00, 2'b00, 2'b11, 6'h00, 6'h00, 5'd0, 16'h0003, 32'd5, 32'd0); tick();
    head("sext_sl2", 1'b1, 32'h0000_0100, 32'd12, 3'b101, 1'b0);
    req(2'b01, 2'b11, 2'b01, 6'h00, 6'h00, 5'd0, 16'h0000, 32'd5, 32'd0); tick();
    head("branch_c4", 1'b1, 32'd0, 32'd4, 3'b110, 1'b0);
    req(2'b01, 2'b10, 2'b11, 6'h00, 6'h00, 5'd7, 16'h8000, 32'd5, 32'd0); tick();
    head("shamt_sl2wrap", 1'b1, 32'd7, 32'hFFFE_0000, 3'b110, 1'b0);
    req(2'b10, 2'b01, 2'b00, 6'h00, 6'h3F, 5'd0, 16'h0000, 32'd6, 32'd8); tick();
    head("bad_funct", 1'b1, 32'd6, 32'd8, 3'b101, 1'b1);
    req(2'b11, 2'b01, 2'b10, 6'h3F, 6'h20, 5'd0, 16'h0001, 32'd6, 32'd8); tick();
    head("bad_opcode", 1'b1, 32'd6, 32'd1, 3'b101, 1'b1);
    idle(); tick();
    head("drained", 1'b0, 32'd0, 32'd0, 3'b101, 1'b0);
    // backpressure: fill DEPTH=2, third request waits at the source
    bus.out_ready = 1'b0;
    req(2'b00, 2'b01, 2'b00, 6'h00, 6'h00, 5'd0, 16'h0000, 32'd1, 32'd0); tick();
    chk("bp1.in_ready", 32'(bus.in_ready), 32'd1);
    head("bp1", 1'b1, 32'd1, 32'd0, 3'b101, 1'b0);
    req(2'b00, 2'b01, 2'b00, 6'h00, 6'h00, 5'd0, 16'h0000, 32'd2, 32'd0); tick();
    chk("bp2.in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp2.a", bus.alu_a, 32'd1);
    req(2'b00, 2'b01, 2'b00, 6'h00, 6'h00, 5'd0, 16'h0000, 32'd3, 32'd0); tick();
    chk("bp3.in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp3.a_stable", bus.alu_a, 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    tick();
    chk("bp4.a", bus.alu_a, 32'd2);
    chk("bp4.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp5.a", bus.alu_a, 32'd3);
    chk("bp5.valid", 32'(bus.out_valid), 32'd1);
    idle(); tick();
    chk("bp6.valid", 32'(bus.out_valid), 32'd0);
    // steady stream: one in and one out every cycle
    for (int i = 0; i < 8; i++) begin
      req(2'b00, 2'b01, 2'b00, 6'h00, 6'h00, 5'd0, 16'h0000, 32'(10 + i), 32'(20 + i)); tick();
      chk($sformatf("stream%0d.a", i), bus.alu_a, 32'(10 + i));
      chk($sformatf("stream%0d.b", i), bus.alu_b, 32'(20 + i));
      chk($sformatf("stream%0d.valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stream%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
    end
    idle(); tick();
    chk("stream_end.valid", 32'(bus.out_valid), 32'd0);
    // flush a full buffer while a push and pop are both offered
    bus.out_ready = 1'b0;
    req(2'b00, 2'b01, 2'b00, 6'h00, 6'h00, 5'd0, 16'h0000, 32'd20, 32'd0); tick();
    req(2'b00, 2'b01, 2'b00, 6'h00, 6'h00, 5'd0, 16'h0000, 32'd21, 32'd0); tick();
    chk("full.in_ready", 32'(bus.in_ready), 32'd0);
    req(2'b00, 2'b01, 2'b00, 6'h00, 6'h00, 5'd0, 16'h0000, 32'd22, 32'd0);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    head("flush", 1'b0, 32'd0, 32'd0, 3'b101, 1'b0);
    chk("flush.in_ready", 32'(bus.in_ready), 32'd1);
    idle();
    flush = 1'b0;
    tick();
    chk("post_flush.valid", 32'(bus.out_valid), 32'd0);
    // asynchronous reset between edges with an illegal entry at the head
    bus.out_ready = 1'b0;
    req(2'b10, 2'b01, 2'b00, 6'h00, 6'h3F, 5'd0, 16'h0000, 32'd30, 32'd31); tick();
    head("pre_rst", 1'b1, 32'd30, 32'd31, 3'b101, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    head("async_rst", 1'b0, 32'd0, 32'd0, 3'b101, 1'b0);
    chk("async_rst.in_ready", 32'(bus.in_ready), 32'd1);
    idle();
    rst_n = 1'b1;
    tick();
    chk("after_rst.valid", 32'(bus.out_valid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
